// File: rtl/xmas_scene_ctrl_if.sv
// Xmas VGA scene controller bus: vsync/button inputs
// and renderer config outputs, bundled for the sequencer.
interface xmas_scene_ctrl_if;
  logic       vsync;
  logic       btn_next;
  logic       btn_pause;
  logic [1:0] scene;
  logic [7:0] lights;
  logic [9:0] snow_y;
  logic       star_on;
  logic       cfg_upd;

  modport master (
    output vsync,
    output btn_next,
    output btn_pause,
    input  scene,
    input  lights,
    input  snow_y,
    input  star_on,
    input  cfg_upd
  );

  modport slave (
    input  vsync,
    input  btn_next,
    input  btn_pause,
    output scene,
    output lights,
    output snow_y,
    output star_on,
    output cfg_upd
  );
endinterface

// File: rtl/xmas_scene_ctrl.sv
// Frame-synchronous scene sequencer for the Xmas VGA card.
// All config state moves only on the vsync falling edge.
module xmas_scene_ctrl #(
  parameter int          SCENE_FRAMES    = 600,
  parameter int          FRAMES_PER_STEP = 30,
  parameter int          SNOW_STEP       = 2,
  parameter int          SNOW_WRAP       = 600,
  parameter logic [7:0]  LIGHT_INIT      = 8'h55
) (
  input logic              clk,
  input logic              reset,
  xmas_scene_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_BLANK  = 2'd0,
    S_TREE   = 2'd1,
    S_LIGHTS = 2'd2,
    S_SNOW   = 2'd3
  } state_t;

  localparam logic [9:0]  SC_LAST = 10'(SCENE_FRAMES - 1);
  localparam logic [7:0]  ST_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [10:0] SN_INC  = 11'(SNOW_STEP);
  localparam logic [10:0] SN_WRAP = 11'(SNOW_WRAP);

  state_t      r_state;
  logic [7:0]  r_lights;
  logic [9:0]  r_snow_y;
  logic        r_star_on;
  logic        r_cfg_upd;
  logic        r_vs_d;
  logic        r_btn_d;
  logic        r_next_pend;
  logic [9:0]  r_scene_cnt;
  logic [7:0]  r_step_cnt;
  logic [1:0]  r_blank_cnt;

  logic        w_tick;
  logic        w_rise;
  logic        w_exit;
  logic [7:0]  w_step_nxt;
  logic        w_step_hit;
  logic [10:0] w_snow_sum;
  logic [10:0] w_snow_nxt;
  logic [7:0]  w_lights_rot;

  assign w_tick = r_vs_d & ~bus.vsync;
  assign w_rise = bus.btn_next & ~r_btn_d;
  assign w_exit = (r_scene_cnt == SC_LAST)
                | r_next_pend;

  // step counter runs modulo FRAMES_PER_STEP;
  // the animation steps when it lands on the last value
  assign w_step_nxt = (r_step_cnt == ST_LAST)
                    ? 8'd0 : r_step_cnt + 8'd1;
  assign w_step_hit = (w_step_nxt == ST_LAST);

  assign w_snow_sum = {1'b0, r_snow_y} + SN_INC;
  assign w_snow_nxt = (w_snow_sum >= SN_WRAP)
                    ? w_snow_sum - SN_WRAP
                    : w_snow_sum;

  assign w_lights_rot = {r_lights[6:0], r_lights[7]};

  assign bus.scene   = r_state;
  assign bus.lights  = r_lights;
  assign bus.snow_y  = r_snow_y;
  assign bus.star_on = r_star_on;
  assign bus.cfg_upd = r_cfg_upd;

  // edge detect, skip latch and frame-tick scene FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_BLANK;
      r_lights    <= 8'd0;
      r_snow_y    <= 10'd0;
      r_star_on   <= 1'b0;
      r_cfg_upd   <= 1'b0;
      r_vs_d      <= 1'b1;
      r_btn_d     <= 1'b0;
      r_next_pend <= 1'b0;
      r_scene_cnt <= 10'd0;
      r_step_cnt  <= 8'd0;
      r_blank_cnt <= 2'd0;
    end else begin
      r_vs_d    <= bus.vsync;
      r_btn_d   <= bus.btn_next;
      r_cfg_upd <= w_tick;
      if (w_tick)
        r_next_pend <= 1'b0;
      else if (w_rise)
        r_next_pend <= 1'b1;
      if (w_tick) begin
        unique case (r_state)
          S_BLANK: begin
            if (r_blank_cnt == 2'd1) begin
              r_state     <= S_TREE;
              r_star_on   <= 1'b1;
              r_lights    <= 8'd0;
              r_scene_cnt <= 10'd0;
            end else begin
              r_blank_cnt <= r_blank_cnt + 2'd1;
            end
          end
          S_TREE: begin
            if (w_exit) begin
              r_state     <= S_LIGHTS;
              r_lights    <= LIGHT_INIT;
              r_star_on   <= 1'b1;
              r_step_cnt  <= 8'd0;
              r_scene_cnt <= 10'd0;
            end else if (!bus.btn_pause) begin
              r_scene_cnt <= r_scene_cnt + 10'd1;
            end
          end
          S_LIGHTS: begin
            if (w_exit) begin
              r_state     <= S_SNOW;
              r_snow_y    <= 10'd0;
              r_scene_cnt <= 10'd0;
            end else if (!bus.btn_pause) begin
              r_scene_cnt <= r_scene_cnt + 10'd1;
              r_step_cnt  <= w_step_nxt;
              if (w_step_hit) begin
                r_lights  <= w_lights_rot;
                r_star_on <= ~r_star_on;
              end
            end
          end
          S_SNOW: begin
            if (w_exit) begin
              r_state     <= S_TREE;
              r_star_on   <= 1'b1;
              r_lights    <= 8'd0;
              r_scene_cnt <= 10'd0;
            end else if (!bus.btn_pause) begin
              r_scene_cnt <= r_scene_cnt + 10'd1;
              r_step_cnt  <= w_step_nxt;
              r_snow_y    <= 10'(w_snow_nxt);
              if (w_step_hit)
                r_star_on <= ~r_star_on;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xmas_scene_ctrl.sv
// Directed bench for xmas_scene_ctrl with short
// scene/step timing so every scene is reached quickly.
module tb_xmas_scene_ctrl;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  xmas_scene_ctrl_if bus ();

  xmas_scene_ctrl #(
    .SCENE_FRAMES   (4),
    .FRAMES_PER_STEP(2),
    .SNOW_STEP      (250),
    .SNOW_WRAP      (600),
    .LIGHT_INIT     (8'h55)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [1:0] sc,
                         input logic [7:0] li,
                         input logic [9:0] sy,
                         input logic       st);
    chk({tag, "_scene"},  32'(bus.scene),   32'(sc));
    chk({tag, "_lights"}, 32'(bus.lights),  32'(li));
    chk({tag, "_snow"},   32'(bus.snow_y),  32'(sy));
    chk({tag, "_star"},   32'(bus.star_on), 32'(st));
  endtask

  // one vsync falling edge; returns just after the tick edge
  task automatic frame();
    @(negedge clk) bus.vsync = 1'b0;
    @(negedge clk) bus.vsync = 1'b1;
  endtask

  task automatic pulse_next();
    @(negedge clk) bus.btn_next = 1'b1;
    @(negedge clk) bus.btn_next = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset         = 1'b1;
    bus.vsync     = 1'b1;
    bus.btn_next  = 1'b0;
    bus.btn_pause = 1'b0;

    // reset holds outputs at zero, even with vsync falling
    repeat (3) @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    chk_out("rst", 2'd0, 8'h00, 10'd0, 1'b0);
    chk("rst_cfg", 32'(bus.cfg_upd), 32'd0);
    bus.vsync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // two ticks in BLANK, then TREE
    frame();
    chk("t1_scene", 32'(bus.scene), 32'd0);
    chk("t1_cfg", 32'(bus.cfg_upd), 32'd1);
    @(negedge clk);
    chk("t1_cfg_off", 32'(bus.cfg_upd), 32'd0);
    frame();
    chk_out("t2", 2'd1, 8'h00, 10'd0, 1'b1);
    chk("t2_cfg", 32'(bus.cfg_upd), 32'd1);

    // no vsync edge: nothing moves
    repeat (20) @(negedge clk);
    chk("idle_cfg", 32'(bus.cfg_upd), 32'd0);
    chk("idle_scene", 32'(bus.scene), 32'd1);

    // free run: TREE x4, LIGHTS x4, SNOW x4, TREE
    frame(); chk("tr3", 32'(bus.scene), 32'd1);
    frame(); chk("tr4", 32'(bus.scene), 32'd1);
    frame(); chk("tr5", 32'(bus.scene), 32'd1);
    frame(); chk_out("li1", 2'd2, 8'h55, 10'd0, 1'b1);
    frame(); chk_out("li2", 2'd2, 8'hAA, 10'd0, 1'b0);
    frame(); chk_out("li3", 2'd2, 8'hAA, 10'd0, 1'b0);
    frame(); chk_out("li4", 2'd2, 8'h55, 10'd0, 1'b1);
    frame(); chk_out("sn1", 2'd3, 8'h55, 10'd0, 1'b1);
    frame(); chk_out("sn2", 2'd3, 8'h55, 10'd250, 1'b1);
    frame(); chk_out("sn3", 2'd3, 8'h55, 10'd500, 1'b0);
    frame(); chk_out("sn4", 2'd3, 8'h55, 10'd150, 1'b0);
    frame(); chk_out("tr_again", 2'd1, 8'h00, 10'd150, 1'b1);

    // two button edges in one frame = one skip
    frame(); chk("tr_b", 32'(bus.scene), 32'd1);
    pulse_next();
    pulse_next();
    frame(); chk_out("skip1", 2'd2, 8'h55, 10'd150, 1'b1);
    frame(); chk_out("skip1b", 2'd2, 8'hAA, 10'd150, 1'b0);

    // pause freezes animation and scene timer
    bus.btn_pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame();
      chk_out("pause", 2'd2, 8'hAA, 10'd150, 1'b0);
    end
    // skip still honoured while paused, entry values load
    pulse_next();
    frame(); chk_out("pskip", 2'd3, 8'hAA, 10'd0, 1'b0);
    bus.btn_pause = 1'b0;
    frame(); chk_out("ps1", 2'd3, 8'hAA, 10'd250, 1'b0);
    frame(); chk_out("ps2", 2'd3, 8'hAA, 10'd500, 1'b1);
    frame(); chk_out("ps3", 2'd3, 8'hAA, 10'd150, 1'b1);

    // timer expiry and pending skip together: one step
    pulse_next();
    frame(); chk_out("both", 2'd1, 8'h00, 10'd150, 1'b1);
    frame(); chk("both_hold", 32'(bus.scene), 32'd1);

    // into SNOW via two skips, then reset mid-scene
    pulse_next();
    frame(); chk("to_li", 32'(bus.scene), 32'd2);
    pulse_next();
    frame(); chk("to_sn", 32'(bus.scene), 32'd3);
    frame(); chk("sn_y", 32'(bus.snow_y), 32'd250);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk_out("rst2", 2'd0, 8'h00, 10'd0, 1'b0);
    chk("rst2_cfg", 32'(bus.cfg_upd), 32'd0);
    frame(); chk("rst2_t1", 32'(bus.scene), 32'd0);
    frame(); chk("rst2_t2", 32'(bus.scene), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
